// File: rtl/pistorm_pkg.sv
// Shared definitions for the 68k-side input qualifiers.
// Contents:
//   IPL_NONE, IPL_NMI : named interrupt priority levels
//   filt_state_e      : glitch-filter state, shared with the bus-error filter
package pistorm_pkg;

  localparam logic [2:0] IPL_NONE = 3'd0;
  localparam logic [2:0] IPL_NMI  = 3'd7;

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } filt_state_e;

endpackage

// File: rtl/ipl_sync_ctrl_if.sv
// Bundle between the 68k IPL pins / host status register and ipl_sync_ctrl.
// Signals:
//   SAMPLE_EN     : strobe, one per 68k clock falling edge
//   IPL_N[2:0]    : raw active-low IPL pins (asynchronous)
//   ACK           : host pulse clearing the pending flags
//   IPL_LEVEL[2:0]: qualified active-high level
//   IRQ_PENDING   : nonzero level latched until ACK
//   NMI_PENDING   : entry into level 7 latched until ACK
//   LEVEL_CHANGED : one-cycle pulse when IPL_LEVEL updates
// master drives the pins/strobe/ACK; slave is the controller.
interface ipl_sync_ctrl_if;
  logic       SAMPLE_EN;
  logic [2:0] IPL_N;
  logic       ACK;
  logic [2:0] IPL_LEVEL;
  logic       IRQ_PENDING;
  logic       NMI_PENDING;
  logic       LEVEL_CHANGED;

  modport master (
    output SAMPLE_EN, IPL_N, ACK,
    input  IPL_LEVEL, IRQ_PENDING, NMI_PENDING, LEVEL_CHANGED
  );

  modport slave (
    input  SAMPLE_EN, IPL_N, ACK,
    output IPL_LEVEL, IRQ_PENDING, NMI_PENDING, LEVEL_CHANGED
  );
endinterface

// File: rtl/sync_chain.sv
// Generic multi-bit, multi-stage synchroniser for asynchronous pins.
// Ports:
//   CLK   : destination clock
//   RESET : synchronous, active-high; loads every stage with RST_VAL
//   d     : asynchronous input
//   q     : synchronised output (last stage)
// Bits are synchronised independently; callers must tolerate per-bit skew.
module sync_chain #(
  parameter int                 WIDTH   = 1,
  parameter int                 DEPTH   = 2,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain, clocked every cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= RST_VAL;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/ipl_sync_ctrl.sv
// 68000 IPL synchroniser, glitch filter and interrupt-pending flag sequencer.
// Ports:
//   CLK   : system clock
//   RESET : synchronous, active-high
//   bus   : ipl_sync_ctrl_if.slave (SAMPLE_EN, IPL_N, ACK in;
//           IPL_LEVEL, IRQ_PENDING, NMI_PENDING, LEVEL_CHANGED out)
// A new level is accepted after FILTER_LEN consecutive identical strobed
// samples; all outputs are registered.
module ipl_sync_ctrl
  import pistorm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2,
  parameter int CNT_W       = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  ipl_sync_ctrl_if.slave    bus
);

  logic [2:0]       sync_n_s;
  logic [2:0]       sync_lvl_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             commit_s;
  logic [2:0]       commit_lvl_s;
  logic             irq_set_s;
  logic             nmi_set_s;

  filt_state_e      state_r;
  logic [2:0]       cand_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       level_r;
  logic             changed_r;
  logic             irq_r;
  logic             nmi_r;

  // Idle pins (all high) reset to level 0 so no spurious request after reset.
  sync_chain #(
    .WIDTH  (3),
    .DEPTH  (SYNC_STAGES),
    .RST_VAL(3'b111)
  ) u_sync (
    .CLK  (CLK),
    .RESET(RESET),
    .d    (bus.IPL_N),
    .q    (sync_n_s)
  );

  assign sync_lvl_s = ~sync_n_s;
  assign cnt_inc_s  = cnt_r + CNT_W'(1);

  // Commit decode: with FILTER_LEN=1 the first differing strobe commits directly.
  always_comb begin
    commit_s     = 1'b0;
    commit_lvl_s = cand_r;
    if (bus.SAMPLE_EN) begin
      case (state_r)
        ST_STABLE: begin
          if ((sync_lvl_s != level_r) && (FILTER_LEN == 1)) begin
            commit_s     = 1'b1;
            commit_lvl_s = sync_lvl_s;
          end else begin
            commit_s     = 1'b0;
          end
        end
        ST_QUALIFY: begin
          if ((sync_lvl_s == cand_r) && (cnt_inc_s == CNT_W'(FILTER_LEN))) begin
            commit_s = 1'b1;
          end else begin
            commit_s = 1'b0;
          end
        end
        default: commit_s = 1'b0;
      endcase
    end else begin
      commit_s = 1'b0;
    end
  end

  assign irq_set_s = commit_s && (commit_lvl_s != IPL_NONE);
  assign nmi_set_s = commit_s && (commit_lvl_s == IPL_NMI) && (level_r != IPL_NMI);

  // Filter FSM plus the qualified level and its change pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= ST_STABLE;
      cand_r    <= IPL_NONE;
      cnt_r     <= '0;
      level_r   <= IPL_NONE;
      changed_r <= 1'b0;
    end else begin
      changed_r <= commit_s;
      if (commit_s) begin
        level_r <= commit_lvl_s;
      end
      if (bus.SAMPLE_EN) begin
        case (state_r)
          ST_STABLE: begin
            if (sync_lvl_s != level_r) begin
              cand_r  <= sync_lvl_s;
              cnt_r   <= CNT_W'(1);
              state_r <= (FILTER_LEN == 1) ? ST_STABLE : ST_QUALIFY;
            end
          end
          ST_QUALIFY: begin
            if (sync_lvl_s == cand_r) begin
              cnt_r <= cnt_inc_s;
              if (commit_s) begin
                state_r <= ST_STABLE;
              end
            end else if (sync_lvl_s == level_r) begin
              // Glitch: input fell back to the committed level.
              state_r <= ST_STABLE;
            end else begin
              cand_r <= sync_lvl_s;
              cnt_r  <= CNT_W'(1);
            end
          end
          default: state_r <= ST_STABLE;
        endcase
      end
    end
  end

  // Pending flags: a set event beats ACK; IRQ re-arms while the level is nonzero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_r <= 1'b0;
      nmi_r <= 1'b0;
    end else begin
      if (irq_set_s) begin
        irq_r <= 1'b1;
      end else if (bus.ACK) begin
        irq_r <= 1'b0;
      end else if (level_r != IPL_NONE) begin
        irq_r <= 1'b1;
      end
      if (nmi_set_s) begin
        nmi_r <= 1'b1;
      end else if (bus.ACK) begin
        nmi_r <= 1'b0;
      end
    end
  end

  assign bus.IPL_LEVEL     = level_r;
  assign bus.LEVEL_CHANGED = changed_r;
  assign bus.IRQ_PENDING   = irq_r;
  assign bus.NMI_PENDING   = nmi_r;

endmodule

// File: tb/tb_ipl_sync_ctrl.sv
// Directed bench for ipl_sync_ctrl (SYNC_STAGES=2, FILTER_LEN=2).
module tb_ipl_sync_ctrl;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;
  int   chg_cnt;

  ipl_sync_ctrl_if bus ();

  ipl_sync_ctrl #(
    .SYNC_STAGES(2),
    .FILTER_LEN (2),
    .CNT_W      (4)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One clock: drive strobe/ack, take the edge, look #1 later.
  task automatic cyc(input logic en, input logic ack);
    bus.SAMPLE_EN = en;
    bus.ACK       = ack;
    @(posedge CLK);
    #1;
    bus.SAMPLE_EN = 1'b0;
    bus.ACK       = 1'b0;
    if (bus.LEVEL_CHANGED === 1'b1) chg_cnt++;
  endtask

  // Present a level and run four continuous strobes (2 sync + 2 filter).
  task automatic qualify(input logic [2:0] lvl);
    bus.IPL_N = ~lvl;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    RESET = 1'b0;
    checks++;
    if (bus.IPL_LEVEL !== 3'd0 || bus.IRQ_PENDING !== 1'b0 ||
        bus.NMI_PENDING !== 1'b0 || bus.LEVEL_CHANGED !== 1'b0) begin
      errors++;
      $display("FAIL reset: got lvl=%0d irq=%b nmi=%b chg=%b want 0 0 0 0",
               bus.IPL_LEVEL, bus.IRQ_PENDING, bus.NMI_PENDING, bus.LEVEL_CHANGED);
    end
  endtask

  task automatic test_slow_strobe();
    chg_cnt   = 0;
    bus.IPL_N = 3'b100;
    for (int k = 1; k <= 12; k++) begin
      cyc((k % 4) == 0, 1'b0);
      if (k == 7) begin
        checks++;
        if (bus.IPL_LEVEL !== 3'd0) begin
          errors++;
          $display("FAIL t1_early: got %0d want 0", bus.IPL_LEVEL);
        end
      end
      if (k == 8) begin
        checks++;
        if (bus.IPL_LEVEL !== 3'd3 || bus.IRQ_PENDING !== 1'b1 || bus.LEVEL_CHANGED !== 1'b1) begin
          errors++;
          $display("FAIL t1_commit: got lvl=%0d irq=%b chg=%b want 3 1 1",
                   bus.IPL_LEVEL, bus.IRQ_PENDING, bus.LEVEL_CHANGED);
        end
      end
    end
    checks++;
    if (chg_cnt !== 1) begin
      errors++;
      $display("FAIL t1_pulses: got %0d want 1", chg_cnt);
    end
  endtask

  task automatic test_glitch();
    qualify(3'd0);
    cyc(1'b0, 1'b1);
    chg_cnt   = 0;
    bus.IPL_N = 3'b010;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    bus.IPL_N = 3'b111;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    checks++;
    if (bus.IPL_LEVEL !== 3'd0 || chg_cnt !== 0 ||
        bus.IRQ_PENDING !== 1'b0 || bus.NMI_PENDING !== 1'b0) begin
      errors++;
      $display("FAIL t2_glitch: got lvl=%0d chg=%0d irq=%b nmi=%b want 0 0 0 0",
               bus.IPL_LEVEL, chg_cnt, bus.IRQ_PENDING, bus.NMI_PENDING);
    end
  endtask

  task automatic test_nmi();
    qualify(3'd2);
    checks++;
    if (bus.IPL_LEVEL !== 3'd2 || bus.NMI_PENDING !== 1'b0) begin
      errors++;
      $display("FAIL t3_lvl2: got lvl=%0d nmi=%b want 2 0", bus.IPL_LEVEL, bus.NMI_PENDING);
    end
    qualify(3'd7);
    checks++;
    if (bus.IPL_LEVEL !== 3'd7 || bus.NMI_PENDING !== 1'b1) begin
      errors++;
      $display("FAIL t3_nmi_set: got lvl=%0d nmi=%b want 7 1", bus.IPL_LEVEL, bus.NMI_PENDING);
    end
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
    checks++;
    if (bus.NMI_PENDING !== 1'b0 || bus.IRQ_PENDING !== 1'b1) begin
      errors++;
      $display("FAIL t3_nmi_ack: got nmi=%b irq=%b want 0 1", bus.NMI_PENDING, bus.IRQ_PENDING);
    end
    qualify(3'd4);
    checks++;
    if (bus.IPL_LEVEL !== 3'd4 || bus.NMI_PENDING !== 1'b0) begin
      errors++;
      $display("FAIL t3_lvl4: got lvl=%0d nmi=%b want 4 0", bus.IPL_LEVEL, bus.NMI_PENDING);
    end
    qualify(3'd7);
    checks++;
    if (bus.NMI_PENDING !== 1'b1) begin
      errors++;
      $display("FAIL t3_nmi_reset: got %b want 1", bus.NMI_PENDING);
    end
  endtask

  task automatic test_ack_collision();
    qualify(3'd0);
    cyc(1'b0, 1'b1);
    checks++;
    if (bus.IRQ_PENDING !== 1'b0 || bus.NMI_PENDING !== 1'b0) begin
      errors++;
      $display("FAIL t4_clear: got irq=%b nmi=%b want 0 0", bus.IRQ_PENDING, bus.NMI_PENDING);
    end
    bus.IPL_N = 3'b000;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    checks++;
    if (bus.IPL_LEVEL !== 3'd7 || bus.IRQ_PENDING !== 1'b1 || bus.NMI_PENDING !== 1'b1) begin
      errors++;
      $display("FAIL t4_set_wins: got lvl=%0d irq=%b nmi=%b want 7 1 1",
               bus.IPL_LEVEL, bus.IRQ_PENDING, bus.NMI_PENDING);
    end
  endtask

  task automatic test_irq_rearm();
    qualify(3'd0);
    cyc(1'b0, 1'b1);
    qualify(3'd4);
    checks++;
    if (bus.IRQ_PENDING !== 1'b1) begin
      errors++;
      $display("FAIL t5_set: got %b want 1", bus.IRQ_PENDING);
    end
    cyc(1'b0, 1'b1);
    checks++;
    if (bus.IRQ_PENDING !== 1'b0) begin
      errors++;
      $display("FAIL t5_ack_gap: got %b want 0", bus.IRQ_PENDING);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (bus.IRQ_PENDING !== 1'b1) begin
      errors++;
      $display("FAIL t5_rearm: got %b want 1", bus.IRQ_PENDING);
    end
    qualify(3'd0);
    checks++;
    if (bus.IPL_LEVEL !== 3'd0 || bus.IRQ_PENDING !== 1'b1) begin
      errors++;
      $display("FAIL t5_latched: got lvl=%0d irq=%b want 0 1", bus.IPL_LEVEL, bus.IRQ_PENDING);
    end
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    checks++;
    if (bus.IRQ_PENDING !== 1'b0) begin
      errors++;
      $display("FAIL t5_cleared: got %b want 0", bus.IRQ_PENDING);
    end
  endtask

  task automatic test_reset_mid_qualify();
    qualify(3'd3);
    bus.IPL_N = 3'b001;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    RESET = 1'b1;
    cyc(1'b1, 1'b0);
    RESET = 1'b0;
    checks++;
    if (bus.IPL_LEVEL !== 3'd0 || bus.IRQ_PENDING !== 1'b0 ||
        bus.NMI_PENDING !== 1'b0 || bus.LEVEL_CHANGED !== 1'b0) begin
      errors++;
      $display("FAIL t6_reset: got lvl=%0d irq=%b nmi=%b chg=%b want 0 0 0 0",
               bus.IPL_LEVEL, bus.IRQ_PENDING, bus.NMI_PENDING, bus.LEVEL_CHANGED);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    checks++;
    if (bus.IPL_LEVEL !== 3'd0) begin
      errors++;
      $display("FAIL t6_restart_early: got %0d want 0", bus.IPL_LEVEL);
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (bus.IPL_LEVEL !== 3'd6 || bus.LEVEL_CHANGED !== 1'b1 ||
        bus.IRQ_PENDING !== 1'b1 || bus.NMI_PENDING !== 1'b0) begin
      errors++;
      $display("FAIL t6_restart: got lvl=%0d chg=%b irq=%b nmi=%b want 6 1 1 0",
               bus.IPL_LEVEL, bus.LEVEL_CHANGED, bus.IRQ_PENDING, bus.NMI_PENDING);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    chg_cnt       = 0;
    RESET         = 1'b1;
    bus.SAMPLE_EN = 1'b0;
    bus.ACK       = 1'b0;
    bus.IPL_N     = 3'b111;
    test_reset();
    test_slow_strobe();
    test_glitch();
    test_nmi();
    test_ack_collision();
    test_irq_rearm();
    test_reset_mid_qualify();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
